// File: rtl/dmem_pkg.sv
// Shared encodings and defaults for the data-memory access controller.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int unsigned MEM_WORDS_DEFAULT = 256;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRmwRd,
        StWr,
        StResp
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane handling: load extract/extend and sub-word store merge.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [4:0]  w_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_sh   = {i_lane, 3'b000};
    assign w_byte = i_rdata[w_sh +: 8];
    assign w_half = i_rdata[{i_lane[1], 4'b0000} +: 16];

    always_comb begin
        o_load_data  = i_rdata;
        o_merge_data = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_load_data  = {{24{~i_unsigned & w_byte[7]}}, w_byte};
                o_merge_data = (i_rdata & ~(32'h0000_00ff << w_sh))
                             | ({24'h0, i_wdata[7:0]} << w_sh);
            end
            SZ_HALF: begin
                o_load_data  = {{16{~i_unsigned & w_half[15]}}, w_half};
                o_merge_data = (i_rdata & ~(32'h0000_ffff << w_sh))
                             | ({16'h0, i_wdata[15:0]} << w_sh);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store initiator for a word-addressed data memory with read-modify-write
// for sub-word stores; one request outstanding, all outputs registered.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        memread,
    output logic        memwrite,
    output logic [31:0] address,
    output logic [31:0] writedata,
    input  logic [31:0] readdata
);

    state_e      r_state;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_memread;
    logic        r_memwrite;
    logic [31:0] r_address;
    logic [31:0] r_writedata;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic [31:0] r_wdata;

    logic        w_err;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    always_comb begin
        w_err = 1'b0;
        case (req_size)
            SZ_BYTE: w_err = 1'b0;
            SZ_HALF: w_err = req_addr[0];
            SZ_WORD: w_err = |req_addr[1:0];
            default: w_err = 1'b1;
        endcase
        if ({2'b00, req_addr[31:2]} >= MEM_WORDS) w_err = 1'b1;
    end

    dmem_lane_align u_lane_align (
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_lane       (r_lane),
        .i_rdata      (readdata),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_memread   <= 1'b0;
            r_memwrite  <= 1'b0;
            r_address   <= 32'h0;
            r_writedata <= 32'h0;
            r_size      <= SZ_BYTE;
            r_unsigned  <= 1'b0;
            r_lane      <= 2'b00;
            r_wdata     <= 32'h0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_lane      <= req_addr[1:0];
                        r_wdata     <= req_wdata;
                        r_address   <= {req_addr[31:2], 2'b00};
                        if (w_err) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 32'h0;
                            r_state     <= StResp;
                        end else if (!req_we) begin
                            r_memread <= 1'b1;
                            r_state   <= StLoad;
                        end else if (req_size == SZ_WORD) begin
                            r_memwrite  <= 1'b1;
                            r_writedata <= req_wdata;
                            r_state     <= StWr;
                        end else begin
                            r_memread <= 1'b1;
                            r_state   <= StRmwRd;
                        end
                    end
                end
                StLoad: begin
                    r_memread   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= w_load_data;
                    r_state     <= StResp;
                end
                StRmwRd: begin
                    r_memread   <= 1'b0;
                    r_memwrite  <= 1'b1;
                    r_writedata <= w_merge_data;
                    r_state     <= StWr;
                end
                StWr: begin
                    r_memwrite  <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'h0;
                    r_state     <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= 32'h0;
                        r_req_ready <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign memread   = r_memread;
    assign memwrite  = r_memwrite;
    assign address   = r_address;
    assign writedata = r_writedata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized self-checking bench for dmem_access_ctrl against a byte-level memory model.
module tb_dmem_access_ctrl;

    localparam int unsigned MEM_WORDS = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        memread;
    logic        memwrite;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    int          checks = 0;
    int          errors = 0;

    dmem_access_ctrl #(.MEM_WORDS(MEM_WORDS)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .memread      (memread),
        .memwrite     (memwrite),
        .address      (address),
        .writedata    (writedata),
        .readdata     (readdata)
    );

    always #5 clk = ~clk;

    // Attached memory: combinational read, write on the rising edge.
    assign readdata = (memread && ((address >> 2) < MEM_WORDS)) ? mem[address[9:2]] : 32'h0;
    always @(posedge clk) begin
        if (memwrite && ((address >> 2) < MEM_WORDS)) mem[address[9:2]] <= writedata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
               (size == 2'd2 && addr % 4 != 0) || (addr / 4 >= MEM_WORDS);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr);
        logic [31:0] w;
        longint      v;
        int          off;
        w   = ref_mem[int'(addr / 4)];
        off = int'(addr % 4);
        case (size)
            2'd0: begin
                v = longint'((w >> (8 * off)) % 256);
                if (!uns && v >= 128) v = v - 256;
            end
            2'd1: begin
                v = longint'((w >> (8 * off)) % 65536);
                if (!uns && v >= 32768) v = v - 65536;
            end
            default: v = longint'(w);
        endcase
        return v[31:0];
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] neww);
        logic [7:0]  b [4];
        logic [31:0] w;
        int          idx;
        int          off;
        idx = int'(addr / 4);
        off = int'(addr % 4);
        w   = ref_mem[idx];
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        if (size == 2'd0) begin
            b[off] = wdata[7:0];
        end else if (size == 2'd1) begin
            b[off]     = wdata[7:0];
            b[off + 1] = wdata[15:8];
        end else begin
            for (int i = 0; i < 4; i++) b[i] = wdata[8*i +: 8];
        end
        neww = {b[3], b[2], b[1], b[0]};
        ref_mem[idx] = neww;
    endtask

    task automatic set_word(input int idx, input logic [31:0] v);
        mem[idx]     = v;
        ref_mem[idx] = v;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", {31'h0, req_ready}, 32'h1);
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                          output logic [31:0] got);
        logic        err;
        int          exp_lat, exp_rd, exp_wr, lat, rd_cnt, wr_cnt;
        logic [31:0] exp_rdata, exp_wd, exp_addr, held_rdata;
        logic        held_err;

        err       = model_err(size, addr);
        exp_rdata = 32'h0;
        exp_wd    = 32'h0;
        exp_addr  = {addr[31:2], 2'b00};
        if (err) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!we) begin
            exp_lat = 2; exp_rd = 1; exp_wr = 0;
            exp_rdata = model_load(size, uns, addr);
        end else begin
            model_store(size, addr, wdata, exp_wd);
            exp_lat = (size == 2'd2) ? 2 : 3;
            exp_rd  = (size == 2'd2) ? 0 : 1;
            exp_wr  = 1;
        end

        wait_ready();
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;

        lat = 1; rd_cnt = 0; wr_cnt = 0;
        while (!rsp_valid && lat < 10) begin
            chk("strobe_excl", {31'h0, memread & memwrite}, 32'h0);
            chk("req_ready_busy", {31'h0, req_ready}, 32'h0);
            if (memread) begin
                rd_cnt++;
                chk("rd_address", address, exp_addr);
            end
            if (memwrite) begin
                wr_cnt++;
                chk("wr_address", address, exp_addr);
                chk("writedata", writedata, exp_wd);
            end
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, err});
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("memread_cnt", rd_cnt, exp_rd);
        chk("memwrite_cnt", wr_cnt, exp_wr);
        chk("strobe_in_resp", {30'h0, memread, memwrite}, 32'h0);
        got        = rsp_rdata;
        held_rdata = rsp_rdata;
        held_err   = rsp_err;

        for (int i = 0; i < hold; i++) begin
            req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
            req_addr = 32'($urandom_range(0, MEM_WORDS * 4 - 1)); req_wdata = $urandom;
            @(negedge clk);
            chk("hold_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("hold_rsp_rdata", rsp_rdata, held_rdata);
            chk("hold_rsp_err", {31'h0, rsp_err}, {31'h0, held_err});
            chk("hold_req_ready", {31'h0, req_ready}, 32'h0);
            chk("hold_strobes", {30'h0, memread, memwrite}, 32'h0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_hs_req_ready", {31'h0, req_ready}, 32'h1);
        chk("post_hs_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h0);
        chk({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_rsp_err"}, {31'h0, rsp_err}, 32'h0);
        chk({tag, "_memread"}, {31'h0, memread}, 32'h0);
        chk({tag, "_memwrite"}, {31'h0, memwrite}, 32'h0);
        chk({tag, "_address"}, address, 32'h0);
        chk({tag, "_writedata"}, writedata, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;
        int          n;

        for (int i = 0; i < int'(MEM_WORDS); i++) set_word(i, $urandom);

        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready_after_reset", {31'h0, req_ready}, 32'h1);

        // Directed vectors.
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, got);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, got);
        chk("tp_word_load", got, 32'hDEADBEEF);

        set_word(4, 32'h11223344);
        do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 0, got);
        chk("tp_byte_store_mem", mem[4], 32'hA5223344);

        set_word(4, 32'h80013344);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0, got);
        chk("tp_half_s", got, 32'hFFFF8001);
        do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, got);
        chk("tp_half_u", got, 32'h00008001);
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, got);
        chk("tp_byte_s", got, 32'hFFFFFF80);
        do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 0, got);
        chk("tp_byte_u", got, 32'h00000044);

        do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 0, got);
        do_req(1'b1, 2'd1, 1'b0, 32'h11, 32'h1234, 0, got);
        do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 0, got);
        do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 0, got);
        chk("tp_err_store_untouched", mem[4], 32'h80013344);

        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, got);
        chk("tp_hold_load", got, 32'h80013344);

        // Reset during the write cycle of a byte store.
        set_word(8, 32'hCAFEF00D);
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h5A;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!memwrite && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("rst_wr_seen", {31'h0, memwrite}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("midrst_no_rsp", {31'h0, rsp_valid}, 32'h0);
        chk("midrst_mem_kept", mem[8], 32'hCAFEF00D);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, got);

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            r  = int'($urandom_range(0, 9));
            sz = (r == 9) ? 2'd3 : 2'(r % 3);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, MEM_WORDS * 4 - 1));
            if (sz != 2'd0 && $urandom_range(0, 9) < 7) a[1:0] = (sz == 2'd1) ? {a[1], 1'b0} : 2'b00;
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom,
                   int'($urandom_range(0, 3)), got);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        for (int i = 0; i < int'(MEM_WORDS); i += 17) chk("final_mem", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
